// File: rtl/candidate_generator.sv
// Brute-force password candidate enumerator (odometer order, shortest first) feeding the NT-hash stage.
// Optional accepted-candidate counter port enabled by defining CANDGEN_COUNT_EN.
module candidate_generator #(
    parameter int         MAX_LEN  = 20,
    parameter int         MIN_LEN  = 1,
    parameter logic [7:0] CHAR_MIN = 8'h21,
    parameter logic [7:0] CHAR_MAX = 8'h7E
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   cand_ready,
    output logic                   cand_valid,
    output logic [8*MAX_LEN-1:0]   cand_chars,
    output logic [7:0]             cand_len,
    output logic                   busy,
    output logic                   done
`ifdef CANDGEN_COUNT_EN
    ,
    output logic [63:0]            cand_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [8*MAX_LEN-1:0] chars_q, chars_d;
    logic [7:0]           len_q, len_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
`ifdef CANDGEN_COUNT_EN
    logic [63:0]          count_q, count_d;
`endif

    logic [8*MAX_LEN-1:0] inc_chars;
    logic                 carry;
    logic                 accept;

    function automatic logic [8*MAX_LEN-1:0] fill_min(input logic [7:0] n);
        logic [8*MAX_LEN-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (8'(i) < n) r[8*i +: 8] = CHAR_MIN;
        end
        return r;
    endfunction

    // Odometer increment over the active positions; carry survives only if every active digit wrapped.
    always_comb begin
        inc_chars = chars_q;
        carry     = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (carry && (8'(i) < len_q)) begin
                if (chars_q[8*i +: 8] == CHAR_MAX) begin
                    inc_chars[8*i +: 8] = CHAR_MIN;
                end else begin
                    inc_chars[8*i +: 8] = chars_q[8*i +: 8] + 8'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    assign accept = valid_q && cand_ready;

    always_comb begin
        state_d = state_q;
        chars_d = chars_q;
        len_d   = len_q;
        valid_d = valid_q;
        done_d  = done_q;
`ifdef CANDGEN_COUNT_EN
        count_d = count_q;
`endif
        if (abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = RUN;
                        valid_d = 1'b1;
                        done_d  = 1'b0;
                        len_d   = 8'(MIN_LEN);
                        chars_d = fill_min(8'(MIN_LEN));
`ifdef CANDGEN_COUNT_EN
                        count_d = '0;
`endif
                    end
                end
                RUN: begin
                    if (accept) begin
`ifdef CANDGEN_COUNT_EN
                        if (count_q != '1) count_d = count_q + 64'd1;
`endif
                        if (!carry) begin
                            chars_d = inc_chars;
                        end else if (len_q < 8'(MAX_LEN)) begin
                            len_d   = len_q + 8'd1;
                            chars_d = fill_min(len_q + 8'd1);
                        end else begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            chars_q <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef CANDGEN_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            chars_q <= chars_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            done_q  <= done_d;
`ifdef CANDGEN_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

    assign cand_valid = valid_q;
    assign busy       = valid_q;
    assign done       = done_q;
    assign cand_chars = chars_q;
    assign cand_len   = len_q;
`ifdef CANDGEN_COUNT_EN
    assign cand_count = count_q;
`endif

endmodule
